// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-fed command RAM: frame width, command codes
// and read-sequencer states.
package spi_ram_pkg;

    localparam int FRAME_W = 10;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_PEND = 2'd1,
        RD_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/sp_ram_array.sv
// Synchronous single-port RAM: write-first is not needed, rdata returns
// the word stored before the clock edge. No reset on contents or rdata.
module sp_ram_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder between the SPI slave and a single-port RAM: latches
// read/write addresses, performs writes, and returns read data on a held tx_valid.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int ADDR_SIZE   = 8,
    parameter int WR_AUTO_INC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] din,
    input  logic               rx_valid,
    output logic [7:0]         dout,
    output logic               tx_valid,
    output logic               cmd_err
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_e        state_q, state_d;
    logic          rx_prev_q, rx_prev_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          wr_ok_q, wr_ok_d;
    logic          rd_ok_q, rd_ok_d;
    logic [7:0]    dout_q, dout_d;
    logic          tx_valid_q, tx_valid_d;
    logic          cmd_err_q, cmd_err_d;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    logic                 accept;
    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] addr_field;
    logic [AW-1:0]        addr_trunc;

    assign accept     = rx_valid & ~rx_prev_q;
    assign cmd        = cmd_e'(din[9:8]);
    assign addr_field = din[ADDR_SIZE-1:0];
    assign addr_trunc = addr_field[AW-1:0];

    sp_ram_array #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW),
        .DW    (8)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        rx_prev_d  = rx_valid;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wr_ok_d    = wr_ok_q;
        rd_ok_d    = rd_ok_q;
        dout_d     = dout_q;
        tx_valid_d = tx_valid_q;
        cmd_err_d  = cmd_err_q;
        mem_we     = 1'b0;
        mem_addr   = rd_addr_q;
        mem_wdata  = din[7:0];

        case (state_q)
            RD_PEND: begin
                // RAM was addressed with rd_addr on the accepting edge; rdata is ready now.
                dout_d     = mem_rdata;
                tx_valid_d = 1'b1;
                rd_ok_d    = 1'b0;
                state_d    = RD_HOLD;
            end
            default: begin
                if (accept) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                    case (cmd)
                        CMD_WR_ADDR: begin
                            wr_addr_d = addr_trunc;
                            wr_ok_d   = 1'b1;
                        end
                        CMD_WR_DATA: begin
                            mem_we   = 1'b1;
                            mem_addr = wr_addr_q;
                            if (WR_AUTO_INC != 0) begin
                                wr_addr_d = wr_addr_q + AW'(1);
                            end
                            if (!wr_ok_q) begin
                                cmd_err_d = 1'b1;
                            end
                        end
                        CMD_RD_ADDR: begin
                            rd_addr_d = addr_trunc;
                            rd_ok_d   = 1'b1;
                        end
                        CMD_RD_DATA: begin
                            state_d = RD_PEND;
                            if (!rd_ok_q) begin
                                cmd_err_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rx_prev_q  <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_ok_q    <= 1'b0;
            rd_ok_q    <= 1'b0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_prev_q  <= rx_prev_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wr_ok_q    <= wr_ok_d;
            rd_ok_q    <= rd_ok_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed, table-driven bench for spi_ram_ctrl, with a second instance
// built with write auto-increment.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din0, din1;
    logic       rxv0, rxv1;
    logic [7:0] dout0, dout1;
    logic       tv0, tv1;
    logic       err0, err1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    spi_ram_ctrl #(
        .MEM_DEPTH   (256),
        .ADDR_SIZE   (8),
        .WR_AUTO_INC (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din0),
        .rx_valid (rxv0),
        .dout     (dout0),
        .tx_valid (tv0),
        .cmd_err  (err0)
    );

    spi_ram_ctrl #(
        .MEM_DEPTH   (256),
        .ADDR_SIZE   (8),
        .WR_AUTO_INC (1)
    ) dut_inc (
        .clk      (clk),
        .rst      (rst),
        .din      (din1),
        .rx_valid (rxv1),
        .dout     (dout1),
        .tx_valid (tv1),
        .cmd_err  (err1)
    );

    typedef struct {
        logic [9:0] frame;
        logic [7:0] exp_dout;
        logic       exp_tv;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Raise rx_valid for 'hold' cycles, then one low cycle; entered and left at posedge+1.
    task automatic send(input int which, input logic [9:0] f, input int hold);
        if (which == 0) begin din0 = f; rxv0 = 1'b1; end
        else            begin din1 = f; rxv1 = 1'b1; end
        repeat (hold) @(posedge clk);
        #1;
        rxv0 = 1'b0;
        rxv1 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; din0 = '0; din1 = '0; rxv0 = 1'b0; rxv1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_dout", dout0, 8'h00);
        check("reset_tv", {7'd0, tv0}, 8'h00);
        check("reset_err", {7'd0, err0}, 8'h00);

        // Read without RD_ADDR: error flag, data from address 0, latency 2.
        send(0, 10'h000, 2);
        send(0, 10'h177, 2);
        check("wr_no_err", {7'd0, err0}, 8'h00);
        din0 = 10'h300; rxv0 = 1'b1;
        @(posedge clk); #1;
        check("noaddr_rd_lat1_tv", {7'd0, tv0}, 8'h00);
        check("noaddr_rd_err", {7'd0, err0}, 8'h01);
        @(posedge clk); #1;
        check("noaddr_rd_lat2_tv", {7'd0, tv0}, 8'h01);
        check("noaddr_rd_dout", dout0, 8'h77);
        rxv0 = 1'b0;
        @(posedge clk); #1;
        check("hold_tv", {7'd0, tv0}, 8'h01);
        rxv0 = 1'b1;
        @(posedge clk); #1;
        check("b2b_rd_drop_tv", {7'd0, tv0}, 8'h00);
        @(posedge clk); #1;
        check("b2b_rd_rise_tv", {7'd0, tv0}, 8'h01);
        check("b2b_rd_dout", dout0, 8'h77);
        check("b2b_rd_err_sticky", {7'd0, err0}, 8'h01);
        rxv0 = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a frame, away from the clock edge.
        din0 = 10'h0AB; rxv0 = 1'b1;
        #3 rst = 1'b1;
        #1;
        check("async_rst_dout", dout0, 8'h00);
        check("async_rst_tv", {7'd0, tv0}, 8'h00);
        check("async_rst_err", {7'd0, err0}, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; rxv0 = 1'b0;
        @(posedge clk); #1;

        vecs.push_back('{10'h012, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{10'h1A5, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{10'h212, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{10'h300, 8'hA5, 1'b1, 1'b0});
        vecs.push_back('{10'h15A, 8'hA5, 1'b0, 1'b0});
        vecs.push_back('{10'h212, 8'hA5, 1'b0, 1'b0});
        vecs.push_back('{10'h300, 8'h5A, 1'b1, 1'b0});
        vecs.push_back('{10'h000, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{10'h1C3, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{10'h200, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{10'h300, 8'hC3, 1'b1, 1'b0});
        vecs.push_back('{10'h300, 8'hC3, 1'b1, 1'b1});
        foreach (vecs[i]) begin
            send(0, vecs[i].frame, 2);
            check($sformatf("vec%0d_dout", i), dout0, vecs[i].exp_dout);
            check($sformatf("vec%0d_tv", i), {7'd0, tv0}, {7'd0, vecs[i].exp_tv});
            check($sformatf("vec%0d_err", i), {7'd0, err0}, {7'd0, vecs[i].exp_err});
        end

        // Reset while the read is pending: tx_valid must never rise.
        send(0, 10'h212, 2);
        din0 = 10'h300; rxv0 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("pend_rst_tv", {7'd0, tv0}, 8'h00);
        check("pend_rst_dout", dout0, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; rxv0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("pend_rst_quiet%0d", k), {7'd0, tv0}, 8'h00);
        end
        send(0, 10'h212, 2);
        send(0, 10'h300, 2);
        check("post_rst_mem_dout", dout0, 8'h5A);
        check("post_rst_mem_tv", {7'd0, tv0}, 8'h01);
        check("post_rst_mem_err", {7'd0, err0}, 8'h00);

        // Auto-increment instance: one long rx_valid pulse is a single write, address wraps.
        send(1, 10'h0FF, 2);
        send(1, 10'h133, 10);
        send(1, 10'h144, 2);
        send(1, 10'h2FF, 2);
        send(1, 10'h300, 2);
        check("inc_mem_ff", dout1, 8'h33);
        check("inc_mem_ff_tv", {7'd0, tv1}, 8'h01);
        send(1, 10'h200, 2);
        send(1, 10'h300, 2);
        check("inc_wrap_mem_00", dout1, 8'h44);
        check("inc_err", {7'd0, err1}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
